ram_wb: RTL and testbench
=========================

Name: ram_wb

Overview:
- Write-side counterpart of the RAM read decoder (ram_dc).
- Decodes the 8-bit RAM address on write-back and updates eight 16-bit RAM registers RAM_0..RAM_7; these outputs feed the read decoder's RAM_n inputs directly.
- Also drives one memory-mapped output port, IO65_OUT, with a valid/ack handshake to the external device.
- Sits in the CPU write-back stage, clocked by its own stage clock.

Parameters:
- DATA_W, 16, width of RAM words and IO data.
- ADDR_W, 8, width of RAM address.
- IO_OUT_ADDR, 8'h41, address of the output port IO65.
- IO_IN_ADDR, 8'h40, address of the read-only input port IO64; writes to it are ignored.

Ports:
- CLK_WB  in  1  write-back stage clock; all state updates on its rising edge.
- RESET  in  1  synchronous reset, active-high.
- RAM_AD_IN  in  8  write address.
- RAM_IN  in  16  write data.
- RAM_WEN  in  1  write request for this cycle.
- WB_READY  out  1  combinational; low means a write to IO_OUT_ADDR is not accepted this cycle and upstream must hold it.
- RAM_0 .. RAM_7  out  16 each  registered RAM contents.
- IO65_OUT  out  16  registered output-port data.
- IO65_VALID  out  1  registered; high while IO65_OUT holds data not yet acknowledged.
- IO65_ACK  in  1  device consumed IO65_OUT.
- ERR_ADDR  out  1  present only with RAM_WB_ERR_EN.

Behaviour:
- Clock and reset:
  - One clock, CLK_WB.
  - RESET is synchronous and active-high. It is sampled on the rising edge of CLK_WB and overrides every other input that cycle.
  - Reset values: RAM_0..RAM_7 = 16'h0000, IO65_OUT = 16'h0000, IO65_VALID = 0, ERR_ADDR = 0.
- RAM writes:
  - RAM_WEN=1 and RAM_AD_IN in 0..7: RAM_n <= RAM_IN at the next edge (1-cycle latency).
  - These writes are always accepted and never depend on WB_READY.
  - Every other RAM register holds its value.
- WB_READY = !(IO65_VALID && !IO65_ACK).
- Output-port write (RAM_WEN=1, RAM_AD_IN=IO_OUT_ADDR):
  - If WB_READY=1: at the next edge IO65_OUT <= RAM_IN and IO65_VALID <= 1.
  - If WB_READY=0: the write has no effect; upstream must hold RAM_AD_IN, RAM_IN and RAM_WEN stable until WB_READY=1.
- Handshake state machine, 2 states tracked by IO65_VALID (IDLE = 0, PEND = 1):
  - IDLE -> PEND on an accepted IO write.
  - PEND -> IDLE on IO65_ACK=1 with no IO write that cycle.
  - PEND with IO65_ACK=1 and an IO write in the same cycle: stays PEND and IO65_OUT takes the new data (back-to-back transfer).
  - PEND with IO65_ACK=0: IO65_OUT is held stable.
  - IO65_ACK while IDLE is ignored.
- Ignored addresses: writes to IO_IN_ADDR and to any address in 8..63 or 66..255 change no state. With RAM_WB_ERR_EN they set ERR_ADDR.
- RAM_WEN=0: no state change regardless of RAM_AD_IN or RAM_IN; IO65_ACK still processed.
- Reset mid-handshake: IO65_VALID drops to 0 and the pending data is discarded.

Optional Feature:
- RAM_WB_ERR_EN defined:
  - ERR_ADDR port exists.
  - ERR_ADDR is a sticky flag, set at the edge after RAM_WEN=1 with an unmapped or read-only address.
  - ERR_ADDR is cleared only by RESET.
- Undefined: no ERR_ADDR port, no flag logic; invalid writes are silently dropped.

Decomposition:
- Shared package cpu15_pkg holds: DATA_W, ADDR_W, RAM_DEPTH=8, IO_IN_ADDR=8'h40, IO_OUT_ADDR=8'h41, and a data-word typedef. The read decoder ram_dc uses the same package.
- One natural sub-module, ram_wb_ioport: holds the IO65 data register, the valid/ack state and the WB_READY generation.
- Top-level ram_wb handles address decode and the RAM register bank.

Test Plan:
- RESET=1 for 2 cycles with RAM_WEN=1, addr 3, data 16'habcd -> all RAM_n=0, IO65_VALID=0, no write taken.
- Sequential writes to addr 0..7 with data 16'h6535, 7628, 7e6e, abcd, 64a6, 0000, 34b1, 808d -> each RAM_n equals its data one edge after its write; other registers unchanged.
- Write 16'h324f to 8'h41, IO65_ACK=0 for 3 cycles -> IO65_VALID=1 and IO65_OUT=16'h324f held. Then a second write of 16'h1111 -> WB_READY=0, IO65_OUT unchanged. Then pulse IO65_ACK -> IO65_VALID=0 next edge.
- IO65_VALID=1, same cycle IO65_ACK=1 plus write of 16'h5a5a to 8'h41 -> IO65_VALID stays 1 and IO65_OUT=16'h5a5a.
- Writes to 8'h40 and 8'h08 -> no RAM or IO change; with RAM_WB_ERR_EN, ERR_ADDR=1 and stays 1 until RESET.
- Write to addr 2 while IO65_VALID=1 and WB_READY=0 -> RAM_2 still updated next edge.

Source files
------------

// File: rtl/cpu15_pkg.sv
// Shared definitions for the CPU15 RAM read/write decoders (ram_dc, ram_wb).
package cpu15_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int RAM_DEPTH = 8;

    // IO64 is a read-only input port; IO65 is the memory-mapped output port.
    localparam logic [ADDR_W-1:0] IO_IN_ADDR  = 8'h40;
    localparam logic [ADDR_W-1:0] IO_OUT_ADDR = 8'h41;

    typedef logic [DATA_W-1:0] data_t;

    // Output-port handshake: the encoding doubles as the IO65_VALID level.
    typedef enum logic {
        IO_IDLE = 1'b0,
        IO_PEND = 1'b1
    } io_state_t;

    // True when the address selects one of the RAM_0..RAM_7 registers.
    function automatic logic is_ram_addr(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(RAM_DEPTH);
    endfunction

endpackage

// File: rtl/ram_wb_ioport.sv
// IO65 output port: data register, valid/ack handshake and the WB_READY
// back-pressure signal seen by the write-back stage.
module ram_wb_ioport
    import cpu15_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              io_wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              io_ack,
    output logic [DATA_W-1:0] io_data,
    output logic              io_valid,
    output logic              wb_ready
);

    io_state_t         state_reg, state_next;
    logic [DATA_W-1:0] data_reg, data_next;

    // A pending word blocks new IO writes unless it is being acknowledged now.
    assign wb_ready = !((state_reg == IO_PEND) && !io_ack);
    assign io_data  = data_reg;
    assign io_valid = (state_reg == IO_PEND);

    // State and data registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= IO_IDLE;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
        end
    end

    // Next-state: accept writes when ready, retire on ack, chain back-to-back.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        case (state_reg)
            IO_IDLE: begin
                if (io_wr) begin
                    state_next = IO_PEND;
                    data_next  = wr_data;
                end
            end
            IO_PEND: begin
                if (io_ack && io_wr) begin
                    data_next = wr_data;
                end else if (io_ack) begin
                    state_next = IO_IDLE;
                end
            end
            default: state_next = IO_IDLE;
        endcase
    end

endmodule

// File: rtl/ram_wb.sv
// Write-back RAM decoder: updates RAM_0..RAM_7 and feeds the IO65 output port.
// Optional build macro: RAM_WB_ERR_EN adds the sticky ERR_ADDR flag.
module ram_wb
    import cpu15_pkg::*;
(
    input  logic              CLK_WB,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] RAM_AD_IN,
    input  logic [DATA_W-1:0] RAM_IN,
    input  logic              RAM_WEN,
    output logic              WB_READY,
    output logic [DATA_W-1:0] RAM_0,
    output logic [DATA_W-1:0] RAM_1,
    output logic [DATA_W-1:0] RAM_2,
    output logic [DATA_W-1:0] RAM_3,
    output logic [DATA_W-1:0] RAM_4,
    output logic [DATA_W-1:0] RAM_5,
    output logic [DATA_W-1:0] RAM_6,
    output logic [DATA_W-1:0] RAM_7,
    output logic [DATA_W-1:0] IO65_OUT,
    output logic              IO65_VALID,
    input  logic              IO65_ACK
`ifdef RAM_WB_ERR_EN
    ,
    output logic              ERR_ADDR
`endif
);

    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic              io_wr;

    // IO writes are offered to the port; it decides acceptance via WB_READY.
    assign io_wr = RAM_WEN && (RAM_AD_IN == IO_OUT_ADDR);

    genvar gi;
    generate
        for (gi = 0; gi < RAM_DEPTH; gi++) begin : g_ram
            logic [DATA_W-1:0] word_reg;
            logic              word_we;

            assign word_we   = RAM_WEN && (RAM_AD_IN == ADDR_W'(gi));
            assign ram_q[gi] = word_reg;

            // RAM word: never back-pressured, independent of the IO port.
            always_ff @(posedge CLK_WB) begin
                if (RESET) begin
                    word_reg <= '0;
                end else if (word_we) begin
                    word_reg <= RAM_IN;
                end
            end
        end
    endgenerate

    assign RAM_0 = ram_q[0];
    assign RAM_1 = ram_q[1];
    assign RAM_2 = ram_q[2];
    assign RAM_3 = ram_q[3];
    assign RAM_4 = ram_q[4];
    assign RAM_5 = ram_q[5];
    assign RAM_6 = ram_q[6];
    assign RAM_7 = ram_q[7];

    ram_wb_ioport u_ioport (
        .clk      (CLK_WB),
        .srst     (RESET),
        .io_wr    (io_wr),
        .wr_data  (RAM_IN),
        .io_ack   (IO65_ACK),
        .io_data  (IO65_OUT),
        .io_valid (IO65_VALID),
        .wb_ready (WB_READY)
    );

`ifdef RAM_WB_ERR_EN
    logic err_reg;

    // Sticky flag for writes that hit neither RAM nor the output port
    // (IO64 is read-only, so it counts as invalid too).
    always_ff @(posedge CLK_WB) begin
        if (RESET) begin
            err_reg <= 1'b0;
        end else if (RAM_WEN && !is_ram_addr(RAM_AD_IN) && (RAM_AD_IN != IO_OUT_ADDR)) begin
            err_reg <= 1'b1;
        end
    end

    assign ERR_ADDR = err_reg;
`endif

endmodule

// File: tb/tb_ram_wb.sv
// Directed table-driven bench for ram_wb (RAM bank, IO65 handshake, reset).
module tb_ram_wb;

    logic        clk;
    logic        rst;
    logic [7:0]  ad_in;
    logic [15:0] din;
    logic        wen;
    logic        ack;
    logic        wb_ready;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] io_out;
    logic        io_valid;
    logic        err_addr;
    logic [15:0] ram_view [8];

    int pass_cnt  = 0;
    int total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_wb dut (
        .CLK_WB     (clk),
        .RESET      (rst),
        .RAM_AD_IN  (ad_in),
        .RAM_IN     (din),
        .RAM_WEN    (wen),
        .WB_READY   (wb_ready),
        .RAM_0      (r0),
        .RAM_1      (r1),
        .RAM_2      (r2),
        .RAM_3      (r3),
        .RAM_4      (r4),
        .RAM_5      (r5),
        .RAM_6      (r6),
        .RAM_7      (r7),
        .IO65_OUT   (io_out),
        .IO65_VALID (io_valid),
        .IO65_ACK   (ack)
`ifdef RAM_WB_ERR_EN
        ,
        .ERR_ADDR   (err_addr)
`endif
    );

`ifndef RAM_WB_ERR_EN
    assign err_addr = 1'b0;
`endif

    assign ram_view[0] = r0;
    assign ram_view[1] = r1;
    assign ram_view[2] = r2;
    assign ram_view[3] = r3;
    assign ram_view[4] = r4;
    assign ram_view[5] = r5;
    assign ram_view[6] = r6;
    assign ram_view[7] = r7;

    typedef struct {
        logic        rst;
        logic        wen;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        ack;
        logic        chk_ready;
        logic        exp_ready;
        int          chk_idx;
        logic [15:0] exp_ram;
        logic        exp_valid;
        logic [15:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive one vector mid-cycle, check WB_READY before the edge and
    // the registered outputs just after it.
    task automatic apply_vec(input int i);
        @(negedge clk);
        rst   = vecs[i].rst;
        wen   = vecs[i].wen;
        ad_in = vecs[i].addr;
        din   = vecs[i].data;
        ack   = vecs[i].ack;
        #1;
        if (vecs[i].chk_ready) begin
            check($sformatf("v%0d wb_ready", i), {15'd0, wb_ready}, {15'd0, vecs[i].exp_ready});
        end
        @(posedge clk);
        #1;
        check($sformatf("v%0d ram%0d", i, vecs[i].chk_idx), ram_view[vecs[i].chk_idx], vecs[i].exp_ram);
        check($sformatf("v%0d io_valid", i), {15'd0, io_valid}, {15'd0, vecs[i].exp_valid});
        check($sformatf("v%0d io_out", i), io_out, vecs[i].exp_out);
`ifdef RAM_WB_ERR_EN
        check($sformatf("v%0d err_addr", i), {15'd0, err_addr}, {15'd0, vecs[i].exp_err});
`endif
        $display("vec %0d: rst=%b wen=%b addr=%h data=%h ack=%b -> ready=%b valid=%b out=%h err=%b",
                 i, vecs[i].rst, vecs[i].wen, vecs[i].addr, vecs[i].data, vecs[i].ack,
                 wb_ready, io_valid, io_out, err_addr);
    endtask

    logic [15:0] wr_data_tbl [8];

    initial begin
        //            rst   wen   addr   data      ack  chkR  expR  idx  exp_ram   val   out       err
        vecs[0]  = '{1'b1, 1'b1, 8'h03, 16'habcd, 1'b0, 1'b0, 1'b1, 3, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h03, 16'habcd, 1'b0, 1'b1, 1'b1, 3, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 16'h6535, 1'b0, 1'b1, 1'b1, 0, 16'h6535, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h01, 16'h7628, 1'b0, 1'b1, 1'b1, 1, 16'h7628, 1'b0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h02, 16'h7e6e, 1'b0, 1'b1, 1'b1, 2, 16'h7e6e, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h03, 16'habcd, 1'b0, 1'b1, 1'b1, 3, 16'habcd, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h04, 16'h64a6, 1'b0, 1'b1, 1'b1, 4, 16'h64a6, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b1, 5, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h06, 16'h34b1, 1'b0, 1'b1, 1'b1, 6, 16'h34b1, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h07, 16'h808d, 1'b0, 1'b1, 1'b1, 7, 16'h808d, 1'b0, 16'h0000, 1'b0};
        // IO65 write, then held three cycles without ack
        vecs[10] = '{1'b0, 1'b1, 8'h41, 16'h324f, 1'b0, 1'b1, 1'b1, 0, 16'h6535, 1'b1, 16'h324f, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h41, 16'h324f, 1'b0, 1'b1, 1'b0, 1, 16'h7628, 1'b1, 16'h324f, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h41, 16'h324f, 1'b0, 1'b1, 1'b0, 2, 16'h7e6e, 1'b1, 16'h324f, 1'b0};
        // second write while pending: refused
        vecs[13] = '{1'b0, 1'b1, 8'h41, 16'h1111, 1'b0, 1'b1, 1'b0, 3, 16'habcd, 1'b1, 16'h324f, 1'b0};
        // ack pulse with no write: back to idle, data kept
        vecs[14] = '{1'b0, 1'b0, 8'h41, 16'h1111, 1'b1, 1'b1, 1'b1, 4, 16'h64a6, 1'b0, 16'h324f, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 8'h41, 16'haaaa, 1'b0, 1'b1, 1'b1, 5, 16'h0000, 1'b1, 16'haaaa, 1'b0};
        // back-to-back: ack and new write same cycle
        vecs[16] = '{1'b0, 1'b1, 8'h41, 16'h5a5a, 1'b1, 1'b1, 1'b1, 6, 16'h34b1, 1'b1, 16'h5a5a, 1'b0};
        // RAM write while port is stalled still lands
        vecs[17] = '{1'b0, 1'b1, 8'h02, 16'hbeef, 1'b0, 1'b1, 1'b0, 2, 16'hbeef, 1'b1, 16'h5a5a, 1'b0};
        // read-only IO64 and unmapped 0x08 are dropped
        vecs[18] = '{1'b0, 1'b1, 8'h40, 16'hffff, 1'b0, 1'b1, 1'b0, 0, 16'h6535, 1'b1, 16'h5a5a, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 8'h08, 16'hffff, 1'b1, 1'b1, 1'b1, 0, 16'h6535, 1'b0, 16'h5a5a, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 8'h01, 16'hffff, 1'b1, 1'b1, 1'b1, 1, 16'h7628, 1'b0, 16'h5a5a, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 8'hff, 16'h1234, 1'b0, 1'b1, 1'b1, 7, 16'h808d, 1'b0, 16'h5a5a, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 8'h41, 16'hc0de, 1'b0, 1'b1, 1'b1, 3, 16'habcd, 1'b1, 16'hc0de, 1'b1};
        // reset mid-handshake discards pending data and clears the flag
        vecs[23] = '{1'b1, 1'b1, 8'h41, 16'h9999, 1'b0, 1'b1, 1'b0, 2, 16'h0000, 1'b0, 16'h0000, 1'b0};

        wr_data_tbl[0] = 16'h6535; wr_data_tbl[1] = 16'h7628;
        wr_data_tbl[2] = 16'h7e6e; wr_data_tbl[3] = 16'habcd;
        wr_data_tbl[4] = 16'h64a6; wr_data_tbl[5] = 16'h0000;
        wr_data_tbl[6] = 16'h34b1; wr_data_tbl[7] = 16'h808d;

        rst = 1'b1; wen = 1'b0; ad_in = 8'h00; din = 16'h0000; ack = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply_vec(i);
        end

        // after the sequential writes every word must hold its own data
        for (int n = 0; n < 8; n++) begin
            check($sformatf("bank ram%0d", n), ram_view[n], wr_data_tbl[n]);
        end

        for (int i = 10; i < 24; i++) begin
            apply_vec(i);
        end

        // reset cleared the whole bank
        for (int n = 0; n < 8; n++) begin
            check($sformatf("post-reset ram%0d", n), ram_view[n], 16'h0000);
        end

        // ack while idle is ignored; no write follows
        @(negedge clk);
        rst = 1'b0; wen = 1'b0; ack = 1'b1; ad_in = 8'h41; din = 16'h7777;
        @(posedge clk); #1;
        check("idle-ack valid", {15'd0, io_valid}, 16'h0000);
        check("idle-ack out", io_out, 16'h0000);
        check("idle-ack ready", {15'd0, wb_ready}, 16'h0001);
        $display("seq idle-ack: valid=%b out=%h ready=%b", io_valid, io_out, wb_ready);

        // accepted write then reset-free hold with ack low across two edges
        @(negedge clk);
        wen = 1'b1; ack = 1'b0; ad_in = 8'h41; din = 16'h0f0f;
        @(posedge clk); #1;
        @(negedge clk);
        wen = 1'b1; din = 16'hf0f0;
        @(posedge clk); #1;
        check("hold out", io_out, 16'h0f0f);
        check("hold valid", {15'd0, io_valid}, 16'h0001);
        $display("seq hold: valid=%b out=%h", io_valid, io_out);

        @(negedge clk);
        wen = 1'b0; ack = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
